data_memory_unit: RTL
=====================

# data_memory_unit

M-stage data memory for the pipelined MIPS core. It consumes the M-stage decoder's `MemWrite`, `SwMode` and `ByteEnable` together with the ALU address and the forwarded rt value. It performs byte-lane-merged writes, including `swl`/`swr` partial-word stores, into a synchronous word RAM. It returns the raw addressed word to the W stage through a registered output, so it also serves as the data half of the M/W pipeline register.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10 — log2 of word count (1024 words = 4 KiB).

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `PC`  in  32  — PC of the M-stage instruction; used only for the write trace.
- `Addr`  in  32  — byte address from the ALU.
- `WriteData`  in  32  — forwarded rt value.
- `MemWrite`  in  1  — store instruction in M.
- `SwMode`  in  2  — `00` normal store, `01` swl, `10` swr, `11` treated as `00`.
- `ByteEnable`  in  4  — lane mask for lb/sb/lh/sh/lw/sw. It is `0000` for swl/swr.
- `ReadDataW`  out  32  — registered raw word at `Addr` (word-aligned). Load extension is done by the W stage.
- `AddrLow2W`  out  2  — registered `Addr[1:0]`, for W-stage extension.
- `ByteEnableW`  out  4  — registered `ByteEnable`.

## Operation
- Word index is `Addr[DEPTH_LOG2+1:2]`.
  - Address is in range iff `Addr[31:DEPTH_LOG2+2]` is zero.
  - A write to an out-of-range address is suppressed.
  - A read from an out-of-range address registers `32'h0`.
- Normal store (`MemWrite=1`, `SwMode` = `00`/`11`):
  - `ByteEnable` `0001`/`0010`/`0100`/`1000`: `WriteData[7:0]` goes to byte lane 0/1/2/3.
  - `0011`: `WriteData[15:0]` goes to bytes 1:0.
  - `1100`: `WriteData[15:0]` goes to bytes 3:2.
  - `1111`: full word.
  - Any other mask: no write.
- swl (little-endian), with k = `Addr[1:0]`:
  - Memory bytes 0..k ← rt bytes (3−k)..3.
  - Example, k=1: bytes 1:0 ← `WriteData[31:16]`.
- swr, with k = `Addr[1:0]`:
  - Memory bytes k..3 ← rt bytes 0..(3−k).
  - Example, k=2: bytes 3:2 ← `WriteData[15:0]`.
- Unwritten lanes keep their old contents.
  - Merge is a read-modify-write of the addressed word within one cycle.
- Read: every cycle, `ReadDataW` ← `mem[index]` regardless of `MemWrite`.
  - Read-first: a same-cycle write to the same word returns the pre-write value.
  - A store followed by a load to the same word in the next cycle sees the new value.

## Timing
- Write latency: 1 edge. Memory is updated at the rising edge where `MemWrite=1` and `reset=0`.
- Read latency: 1 edge. `ReadDataW`, `AddrLow2W` and `ByteEnableW` reflect the inputs sampled at the previous edge.
- No stall or flush input; the M/W stage never stalls.
- Reset, on any edge with `reset=1`:
  - Every memory word ← 0.
  - `ReadDataW` ← 0, `AddrLow2W` ← 0, `ByteEnableW` ← 0.
  - Any concurrent store is discarded.
- Reset released mid-program: the first post-reset store writes normally on the next edge.
- Simultaneous store and reset: reset wins.

## Configuration
- `DM_TRACE_EN` defined:
  - On every committed write (not suppressed, not in reset), display `time@PC: *byteaddr <= word`.
  - `byteaddr` is the word-aligned address `{index,2'b00}` zero-extended to 32 bits; `word` is the full merged word after the write.
  - Nothing is printed for suppressed writes.
- `DM_TRACE_EN` undefined:
  - No display statements are compiled.
  - `PC` is unused.
  - Functional behaviour is identical.

## Test plan
- Reset then read: `reset=1` for 1 cycle, then read `Addr=0x10` → `ReadDataW=0x00000000`; all outputs are 0 during reset.
- sw/sb merge:
  - sw `0x11223344` @0x20.
  - Then sb `WriteData=0xAB`, `ByteEnable=0100` @0x22.
  - Then load @0x20 → `ReadDataW=0x11AB3344`.
- swl/swr:
  - Word @0x40 = `0xAABBCCDD`, rt = `0x12345678`.
  - swl @0x41 → `0xAABB1234`.
  - Reload, then swr @0x42 → `0x5678CCDD`.
- Read-first / next-cycle:
  - sw `0xDEADBEEF` @0x8 while reading 0x8 in the same cycle → `ReadDataW` = old value.
  - Next-cycle read → `0xDEADBEEF`.
- Out-of-range/illegal:
  - sw @`0x00001000` (DEPTH_LOG2=10) → no write; read there → 0; word 0 unchanged.
  - Store with `ByteEnable=0101` → no write.
- Reset during store: `reset=1` with sw `0xFFFFFFFF` @0x4 → word 0x4 reads 0 afterwards; with `DM_TRACE_EN`, no trace line is printed.

Source files
------------

// File: rtl/data_memory_unit.sv
// data_memory_unit
// M-stage data memory of the pipelined MIPS core and the data half of the
// M/W pipeline register. Stores are byte-lane merged into a synchronous word
// RAM. This includes swl/swr partial-word stores. Every cycle the raw
// addressed word is registered toward the W stage, using read-first
// ordering.
//
// Parameters:
//   DEPTH_LOG2   log2 of the word count (default 1024 words)
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high; clears RAM and W-side registers
//   PC           PC of the M-stage instruction (write trace only)
//   Addr         byte address from the ALU
//   WriteData    forwarded rt value
//   MemWrite     store instruction in M
//   SwMode       00/11 normal store, 01 swl, 10 swr
//   ByteEnable   lane mask for normal loads/stores (0000 for swl/swr)
//   ReadDataW    registered raw word at Addr (0 when out of range)
//   AddrLow2W    registered Addr[1:0]
//   ByteEnableW  registered ByteEnable
// Optional feature: define DM_TRACE_EN to print one line per committed write.

module data_memory_unit #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic [1:0]  SwMode,
   input  logic [3:0]  ByteEnable,
   output logic [31:0] ReadDataW,
   output logic [1:0]  AddrLow2W,
   output logic [3:0]  ByteEnableW
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wordIndex;
   logic                  inRange;
   logic [31:0]           oldWord;
   logic [31:0]           laneData;
   logic [3:0]            laneMask;
   logic [31:0]           mergedWord;
   logic                  doWrite;

   assign wordIndex = Addr[DEPTH_LOG2+1:2];
   assign inRange   = (Addr[31:DEPTH_LOG2+2] == '0);
   assign oldWord   = mem[wordIndex];

   // Lane data is pre-aligned so that byte lane i always takes laneData[8i+7:8i].
   // swl shifts rt right by 3-k bytes. swr shifts it left by k bytes.
   always_comb begin
      laneData = WriteData;
      laneMask = '0;
      unique case (SwMode)
         2'b01: begin
            laneData = WriteData >> (8 * (3 - Addr[1:0]));
            laneMask = 4'b1111 >> (3 - Addr[1:0]);
         end
         2'b10: begin
            laneData = WriteData << (8 * Addr[1:0]);
            laneMask = 4'b1111 << Addr[1:0];
         end
         default: begin
            unique case (ByteEnable)
               4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                  laneData = {4{WriteData[7:0]}};
                  laneMask = ByteEnable;
               end
               4'b0011, 4'b1100: begin
                  laneData = {2{WriteData[15:0]}};
                  laneMask = ByteEnable;
               end
               4'b1111: begin
                  laneData = WriteData;
                  laneMask = 4'b1111;
               end
               default: begin
                  laneData = WriteData;
                  laneMask = '0;
               end
            endcase
         end
      endcase
   end

   always_comb begin
      mergedWord = oldWord;
      for (int unsigned i = 0; i < 4; i++) begin
         if (laneMask[i]) mergedWord[8*i +: 8] = laneData[8*i +: 8];
      end
   end

   assign doWrite = MemWrite && inRange && (laneMask != '0) && !reset;

   // Read-first: the read samples the pre-write word in the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[DEPTH_LOG2'(i)] <= '0;
         end
         ReadDataW   <= '0;
         AddrLow2W   <= '0;
         ByteEnableW <= '0;
      end else begin
         if (doWrite) mem[wordIndex] <= mergedWord;
         ReadDataW   <= inRange ? oldWord : '0;
         AddrLow2W   <= Addr[1:0];
         ByteEnableW <= ByteEnable;
      end
   end

`ifdef DM_TRACE_EN
   logic [31:0] traceAddr;

   always_comb begin
      traceAddr = '0;
      traceAddr[DEPTH_LOG2+1:0] = {wordIndex, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (doWrite) $display("%0t@%h: *%h <= %h", $time, PC, traceAddr, mergedWord);
   end
`else
   logic unusedPc;
   assign unusedPc = ^PC;
`endif

endmodule
